axis_block_serializer: RTL and testbench
========================================

# axis_block_serializer

Transmit-side width converter for the AES datapath. Accepts one 128-bit result block per handshake from the cipher core and emits it as a stream of TDATA_WIDTH-bit AXI-Stream master beats, with tkeep for partial final blocks and tlast marking the end of a message. It sits between the cipher core output and the `axis_if` master modport that drives the external output stream.

## Interface
- TDATA_WIDTH, 32: output beat width in bits. Legal values are 8, 16, 32, 64 and 128; BLOCK_WIDTH must be a multiple of it.
- BLOCK_WIDTH, 128: input block width in bits (one AES block).
- clk  input  1  clock; all logic samples on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- blk_valid  input  1  upstream block available.
- blk_ready  output  1  block accepted when high together with blk_valid.
- blk_data  input  BLOCK_WIDTH  block payload; byte k is at bits [8k+7:8k].
- blk_bytes  input  $clog2(BLOCK_WIDTH/8)+1  count of valid bytes, 1..BLOCK_WIDTH/8. A value of 0 or above BLOCK_WIDTH/8 is treated as BLOCK_WIDTH/8.
- blk_last  input  1  block is the final block of a message.
- m_tvalid  output  1  AXIS master tvalid.
- m_tready  input  1  AXIS master tready.
- m_tdata  output  TDATA_WIDTH  AXIS master tdata.
- m_tkeep  output  TDATA_WIDTH/8  AXIS master tkeep.
- m_tlast  output  1  AXIS master tlast.

## Operation
- Two states:
  - IDLE: no block is held.
  - SEND: a block is held in a BLOCK_WIDTH shift register, with a beat counter and a remaining-byte counter.
- Capture:
  - A block is captured on the edge where blk_valid && blk_ready.
  - This loads blk_data, the saturated byte count and blk_last.
  - The state moves to SEND and word 0 is presented.
- Beat count: beats per block N = ceil(bytes / (TDATA_WIDTH/8)). There are no empty beats; a 1-byte block produces exactly one beat.
- Beat content:
  - Beat i carries blk_data[TDATA_WIDTH*(i+1)-1 : TDATA_WIDTH*i], i.e. the lowest word goes first.
- tkeep:
  - m_tkeep is all ones on every beat except the final one.
  - On the final beat it carries the low r bits set, where r = remaining bytes (1..TDATA_WIDTH/8). Bits are contiguous from bit 0.
- tdata lanes with tkeep 0 carry the block's original data, which is don't-care to the sink.
- m_tlast is 1 only on beat N-1 of a block captured with blk_last=1. Otherwise it is 0.
- Advance:
  - On m_tvalid && m_tready, the shift register moves down one word and the counters decrement.
  - On the final beat's handshake:
    - If blk_valid is high in that same cycle, the next block is captured and the state stays in SEND (back-to-back, no bubble).
    - Otherwise the state goes to IDLE.
- blk_ready = rst_n && (state==IDLE || (m_tvalid && m_tready && final beat)).
  - The combinational path from m_tready to blk_ready is intended.
- Stall: while m_tvalid && !m_tready, m_tdata, m_tkeep and m_tlast hold stable and m_tvalid stays high (AXIS rule). Upstream blocks are not accepted during a stall.
- Reset mid-block: the held block is discarded with no partial tlast. After release the block starts in IDLE.

## Timing
- Reset values:
  - m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0.
  - state=IDLE.
  - blk_ready=0 while rst_n is low.
- First cycle after rst_n rises: blk_ready=1.
- Latency: a block captured at edge E puts beat 0 on m_tvalid/m_tdata immediately after E (registered outputs, 1 cycle).
- Throughput with m_tready held at 1:
  - One beat per cycle.
  - A full 128-bit block at TDATA_WIDTH=32 takes 4 cycles.
  - Consecutive blocks stream with no idle cycle.
- In IDLE, m_tvalid=0 and m_tkeep and m_tlast are driven 0.
- Outputs are registered; blk_ready is the only combinational output.
- Simultaneous final-beat handshake and new blk_valid: both transfers complete on the same edge.

## Test plan
- Single full block: blk_data=0x0F0E0D0C_0B0A0908_07060504_03020100, bytes=16, last=1, m_tready=1.
  - Beats are 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - tkeep=0xF on all four beats; tlast only on beat 3.
  - blk_ready is 1 in the cycle of beat 3.
- Partial block: same data with bytes=6, last=1.
  - Two beats: 0x03020100 with tkeep=0xF, then 0x07060504 with tkeep=0x3 and tlast=1.
  - bytes=1 gives one beat with tkeep=0x1 and tlast=1.
- Back-to-back: three full blocks with last=0,0,1 and blk_valid held high.
  - 12 consecutive valid beats with no gap; tlast only on beat 11.
  - blk_ready pulses on cycles 0, 4 and 8 after reset.
- Random backpressure: m_tready toggled pseudo-randomly over 100 blocks.
  - tdata, tkeep and tlast stay stable during every stall.
  - The scoreboard byte stream equals the input bytes.
- Out-of-range count: bytes=0 and bytes=31 each emit 4 beats with tkeep=0xF.
- Reset mid-block: assert rst_n low after beat 1 of a 4-beat block.
  - m_tvalid drops to 0 asynchronously.
  - After release, the next block emits from beat 0 with no stale data and no tlast from the aborted block.

Source files
------------

// File: rtl/axis_block_serializer_if.sv
// Bundle of the block-side handshake and the AXI-Stream output of the block serializer.
// master: the serializer's view (sinks blocks, drives the stream); slave: the environment.
// Ports: blk_valid/blk_ready/blk_data/blk_bytes/blk_last, m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast.
interface axis_block_serializer_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int BLOCK_WIDTH = 128
);
    localparam int CW = $clog2(BLOCK_WIDTH / 8) + 1;

    logic                     blk_valid;
    logic                     blk_ready;
    logic [BLOCK_WIDTH-1:0]   blk_data;
    logic [CW-1:0]            blk_bytes;
    logic                     blk_last;

    logic                     m_tvalid;
    logic                     m_tready;
    logic [TDATA_WIDTH-1:0]   m_tdata;
    logic [TDATA_WIDTH/8-1:0] m_tkeep;
    logic                     m_tlast;

    modport master (
        input  blk_valid, blk_data, blk_bytes, blk_last, m_tready,
        output blk_ready, m_tvalid, m_tdata, m_tkeep, m_tlast
    );

    modport slave (
        output blk_valid, blk_data, blk_bytes, blk_last, m_tready,
        input  blk_ready, m_tvalid, m_tdata, m_tkeep, m_tlast
    );
endinterface

// File: rtl/axis_block_serializer.sv
// Purpose: splits one BLOCK_WIDTH cipher block into TDATA_WIDTH AXIS beats, low word first, tkeep/tlast on the last beat.
// Latency: beat 0 is presented on the edge after capture; one beat per cycle while m_tready is high.
// Backpressure: m_tready low freezes all stream outputs; blk_ready only rises in IDLE or on the final beat's handshake.
// Ports: clk, rst_n (async active-low), bus (master modport: blk_* block input, m_t* stream output).
module axis_block_serializer #(
    parameter int TDATA_WIDTH = 32,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axis_block_serializer_if.master bus
);
    localparam int BPB = TDATA_WIDTH / 8;          // bytes per beat
    localparam int NB  = BLOCK_WIDTH / 8;          // bytes per block
    localparam int CW  = $clog2(NB) + 1;
    localparam logic [CW-1:0] BPB_C = CW'(BPB);
    localparam logic [CW-1:0] NB_C  = CW'(NB);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [BLOCK_WIDTH-1:0]   sh_q, sh_d;          // block, current beat in the low word
    logic [CW-1:0]            rem_q, rem_d;        // bytes still to send, including the current beat
    logic                     last_q, last_d;
    logic                     tvalid_q, tvalid_d;
    logic [TDATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [BPB-1:0]           tkeep_q, tkeep_d;
    logic                     tlast_q, tlast_d;

    logic                     fire, final_beat, blk_rdy, take;
    logic [CW-1:0]            bytes_sat;

    // Low r lanes set; r at or above the beat width yields all ones.
    function automatic logic [BPB-1:0] keep_mask(input logic [CW-1:0] r);
        logic [BPB-1:0] m;
        m = '0;
        for (int k = 0; k < BPB; k++) begin
            if (k < int'(r)) m[k] = 1'b1;
        end
        return m;
    endfunction

    assign fire       = tvalid_q && bus.m_tready;
    assign final_beat = (rem_q <= BPB_C);
    // Ready on the final handshake lets the next block load on the same edge (no bubble).
    assign blk_rdy    = rst_n && ((state_q == IDLE) || (fire && final_beat));
    assign take       = bus.blk_valid && blk_rdy;

    // Out-of-range counts mean a full block.
    always_comb begin
        bytes_sat = bus.blk_bytes;
        if (bus.blk_bytes == '0 || bus.blk_bytes > NB_C) bytes_sat = NB_C;
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = SEND;
                    sh_d    = bus.blk_data;
                    rem_d   = bytes_sat;
                    last_d  = bus.blk_last;
                end
            end
            SEND: begin
                if (fire) begin
                    if (final_beat) begin
                        if (take) begin
                            sh_d   = bus.blk_data;
                            rem_d  = bytes_sat;
                            last_d = bus.blk_last;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sh_d  = sh_q >> TDATA_WIDTH;
                        rem_d = rem_q - BPB_C;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Stream outputs are registered copies of the beat the next state will present.
        tvalid_d = (state_d == SEND);
        tdata_d  = sh_d[TDATA_WIDTH-1:0];
        tkeep_d  = tvalid_d ? keep_mask(rem_d) : '0;
        tlast_d  = tvalid_d && last_d && (rem_d <= BPB_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            rem_q    <= '0;
            last_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            rem_q    <= rem_d;
            last_q   <= last_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
        end
    end

    assign bus.blk_ready = blk_rdy;
    assign bus.m_tvalid  = tvalid_q;
    assign bus.m_tdata   = tdata_q;
    assign bus.m_tkeep   = tkeep_q;
    assign bus.m_tlast   = tlast_q;
endmodule

// File: tb/tb_axis_block_serializer.sv
// Testbench for axis_block_serializer: directed and randomized blocks against a beat-level reference model.
module tb_axis_block_serializer;
    localparam int TW = 32;
    localparam int BW = 128;
    localparam int KW = TW / 8;
    localparam int NB = BW / 8;
    localparam int CW = $clog2(NB) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_block_serializer_if #(.TDATA_WIDTH(TW), .BLOCK_WIDTH(BW)) bus ();

    axis_block_serializer #(.TDATA_WIDTH(TW), .BLOCK_WIDTH(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [TW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct packed {
        logic [BW-1:0] d;
        logic [CW-1:0] b;
        logic          l;
    } blk_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    blk_t  in_q[$];
    logic  vld_log[$];
    logic  rdy_log[$];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [BW-1:0] full_data = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [BW-1:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference model: a block of b bytes becomes ceil(b/KW) words, lowest first.
    task automatic add_block(input logic [BW-1:0] d, input logic [CW-1:0] b, input logic l);
        int    nb, n, r;
        beat_t bt;
        blk_t  bk;
        bk.d = d; bk.b = b; bk.l = l;
        in_q.push_back(bk);
        nb = (int'(b) == 0 || int'(b) > NB) ? NB : int'(b);
        n  = (nb + KW - 1) / KW;
        for (int i = 0; i < n; i++) begin
            r    = nb - i * KW;
            bt.d = d[i*TW +: TW];
            bt.k = (i < n - 1) ? {KW{1'b1}} : KW'((1 << r) - 1);
            bt.l = l && (i == n - 1);
            exp_q.push_back(bt);
        end
    endtask

    task automatic clear_all();
        exp_q.delete(); got_q.delete(); in_q.delete();
        vld_log.delete(); rdy_log.delete();
    endtask

    // Drives queued blocks, collects handshaken beats, checks stall stability.
    task automatic run(input int ready_pct, input int budget);
        logic  acc = 1'b0;
        logic  stalled = 1'b0;
        beat_t prev = '0;
        beat_t bt;
        int    cyc = 0;
        while ((in_q.size() > 0 || got_q.size() < exp_q.size()) && cyc < budget) begin
            @(posedge clk); #1;
            if (acc) void'(in_q.pop_front());
            bus.blk_valid = (in_q.size() > 0);
            if (in_q.size() > 0) begin
                bus.blk_data  = in_q[0].d;
                bus.blk_bytes = in_q[0].b;
                bus.blk_last  = in_q[0].l;
            end
            bus.m_tready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            acc  = bus.blk_valid && bus.blk_ready;
            bt.d = bus.m_tdata; bt.k = bus.m_tkeep; bt.l = bus.m_tlast;
            vld_log.push_back(bus.m_tvalid);
            rdy_log.push_back(bus.blk_ready);
            if (stalled) begin
                n_cmp++;
                if (!bus.m_tvalid || bt !== prev) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc %0d got vld=%b %h want vld=1 %h", cyc, bus.m_tvalid, bt, prev);
                end
            end
            stalled = bus.m_tvalid && !bus.m_tready;
            prev    = bt;
            if (bus.m_tvalid && bus.m_tready) got_q.push_back(bt);
            cyc++;
        end
        bus.blk_valid = 1'b0;
        n_cmp++;
        if (in_q.size() > 0 || got_q.size() < exp_q.size()) begin
            n_fail++;
            $display("FAIL run_timeout got %0d beats want %0d (blocks left %0d)", got_q.size(), exp_q.size(), in_q.size());
        end
    endtask

    task automatic test_reset();
        bus.blk_valid = 1'b0; bus.blk_data = '0; bus.blk_bytes = '0;
        bus.blk_last = 1'b0; bus.m_tready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.m_tvalid, bus.m_tdata, bus.m_tkeep, bus.m_tlast} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got vld=%b d=%h k=%h l=%b want all 0", bus.m_tvalid, bus.m_tdata, bus.m_tkeep, bus.m_tlast);
        end
        n_cmp++;
        if (bus.blk_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_blk_ready got %b want 0", bus.blk_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.blk_ready !== 1'b1 || bus.m_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset got rdy=%b vld=%b want rdy=1 vld=0", bus.blk_ready, bus.m_tvalid);
        end
    endtask

    task automatic test_full_block();
        clear_all();
        add_block(full_data, CW'(16), 1'b1);
        run(100, 50);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL full_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL full_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (got_q.size() > 0 && got_q[0].d !== 32'h03020100) begin
            n_fail++; $display("FAIL full_first_word got %h want 03020100", got_q[0].d);
        end
        n_cmp++;
        if (rdy_log.size() < 5 || rdy_log[4] !== 1'b1 || vld_log[4] !== 1'b1 ||
            rdy_log[1] !== 1'b0 || rdy_log[2] !== 1'b0 || rdy_log[3] !== 1'b0) begin
            n_fail++; $display("FAIL full_blk_ready pattern got %p want ready only with beat 3", rdy_log);
        end
    endtask

    task automatic test_partial();
        clear_all();
        add_block(full_data, CW'(6), 1'b1);
        add_block(full_data, CW'(1), 1'b1);
        run(100, 50);
        n_cmp++;
        if (got_q.size() != 3) begin
            n_fail++; $display("FAIL partial_count got %0d want 3", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL partial_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (got_q.size() > 2 && (got_q[1].k !== 4'h3 || got_q[2].k !== 4'h1)) begin
            n_fail++; $display("FAIL partial_keep got %h,%h want 3,1", got_q[1].k, got_q[2].k);
        end
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        int bad_rdy = 0;
        clear_all();
        add_block(rand_blk(), CW'(16), 1'b0);
        add_block(rand_blk(), CW'(16), 1'b0);
        add_block(rand_blk(), CW'(16), 1'b1);
        run(100, 100);
        n_cmp++;
        if (got_q.size() != 12) begin
            n_fail++; $display("FAIL b2b_count got %0d want 12", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        for (int c = 1; c <= 12 && c < vld_log.size(); c++) if (vld_log[c] !== 1'b1) gaps++;
        for (int c = 0; c < 12 && c < rdy_log.size(); c++)
            if (rdy_log[c] !== ((c == 0) || (c == 4) || (c == 8))) bad_rdy++;
        n_cmp++;
        if (gaps != 0 || vld_log.size() < 13) begin
            n_fail++; $display("FAIL b2b_gaps got %0d idle cycles (log %0d) want 0", gaps, vld_log.size());
        end
        n_cmp++;
        if (bad_rdy != 0) begin
            n_fail++; $display("FAIL b2b_blk_ready got %0d wrong cycles want pulses at 0,4,8 only", bad_rdy);
        end
    endtask

    task automatic test_out_of_range();
        clear_all();
        add_block(rand_blk(), CW'(0), 1'b1);
        add_block(rand_blk(), CW'(31), 1'b0);
        run(100, 50);
        n_cmp++;
        if (got_q.size() != 8) begin
            n_fail++; $display("FAIL oor_count got %0d want 8", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL oor_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_backpressure();
        clear_all();
        for (int n = 0; n < 100; n++) begin
            logic [CW-1:0] b;
            b = ($urandom_range(9) == 0) ? CW'($urandom_range(31)) : CW'($urandom_range(16, 1));
            add_block(rand_blk(), b, 1'($urandom_range(1)));
        end
        run(55, 4000);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rand_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_block();
        logic [BW-1:0] a;
        a = rand_blk();
        @(posedge clk); #1;
        bus.blk_valid = 1'b1; bus.blk_data = a; bus.blk_bytes = CW'(16);
        bus.blk_last = 1'b1; bus.m_tready = 1'b1;
        @(posedge clk); #1;
        bus.blk_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== a[63:32]) begin
            n_fail++; $display("FAIL abort_beat1 got vld=%b %h want 1 %h", bus.m_tvalid, bus.m_tdata, a[63:32]);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.m_tvalid !== 1'b0 || bus.m_tlast !== 1'b0 || bus.blk_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_async got vld=%b last=%b rdy=%b want 0 0 0", bus.m_tvalid, bus.m_tlast, bus.blk_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_all();
        add_block(rand_blk(), CW'(16), 1'b1);
        run(100, 50);
        n_cmp++;
        if (got_q.size() != 4) begin
            n_fail++; $display("FAIL abort_count got %0d want 4", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL abort_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_partial();
        test_back_to_back();
        test_out_of_range();
        test_random_backpressure();
        test_reset_mid_block();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
